// File: rtl/bootram_ctrl.sv
// Boot RAM controller: bridges picorv32 native memory requests and a byte-serial
// loader onto four byte-lane synchronous RAMs, holding the CPU in reset while loading.
module bootram_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_BITS = 13
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        ram_ce,
    output logic [3:0]  ram_wre,
    output logic [10:0] ram_ad,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        cpu_resetn,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        RESP  = 3'd2,
        WRITE = 3'd3,
        LOAD  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        ram_ce_q, ram_ce_d;
    logic [3:0]  ram_wre_q, ram_wre_d;
    logic [10:0] ram_ad_q, ram_ad_d;
    logic [31:0] ram_din_q, ram_din_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        ld_done_q, ld_done_d;
    logic        cpu_resetn_q, cpu_resetn_d;
    logic [12:0] ld_ptr_q, ld_ptr_d;
    logic        hit;
    logic        unused_addr_lsbs;

    assign hit = mem_valid && (mem_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign unused_addr_lsbs = ^mem_addr[1:0];

    // Loader handshake: a byte moves on any cycle with ld_valid && ld_ready;
    // ld_data and ld_last are only looked at on such a cycle.
    always_comb begin
        state_d     = state_q;
        ram_ce_d    = ram_ce_q;
        ram_wre_d   = ram_wre_q;
        ram_ad_d    = ram_ad_q;
        ram_din_d   = ram_din_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        ld_done_d   = 1'b0;
        ld_ptr_d    = ld_ptr_q;

        case (state_q)
            IDLE: begin
                ram_ce_d  = 1'b0;
                ram_wre_d = 4'b0000;
                if (ld_start) begin
                    state_d  = LOAD;
                    ld_ptr_d = 13'd0;
                end else if (hit && !mem_ready_q) begin
                    // The ready cycle still shows mem_valid; skipping it avoids a repeat access.
                    ram_ce_d = 1'b1;
                    ram_ad_d = mem_addr[12:2];
                    if (mem_wstrb == 4'b0000) begin
                        state_d   = READ;
                        ram_wre_d = 4'b0000;
                    end else begin
                        state_d   = WRITE;
                        ram_wre_d = mem_wstrb;
                        ram_din_d = mem_wdata;
                    end
                end
            end
            READ: begin
                ram_ce_d = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                mem_rdata_d = ram_dout;
                mem_ready_d = 1'b1;
                state_d     = IDLE;
            end
            WRITE: begin
                ram_ce_d    = 1'b0;
                ram_wre_d   = 4'b0000;
                mem_ready_d = 1'b1;
                state_d     = IDLE;
            end
            LOAD: begin
                ram_ce_d  = 1'b0;
                ram_wre_d = 4'b0000;
                if (ld_valid) begin
                    ram_ce_d  = 1'b1;
                    ram_ad_d  = ld_ptr_q[12:2];
                    ram_wre_d = 4'b0001 << ld_ptr_q[1:0];
                    ram_din_d = {4{ld_data}};
                    ld_ptr_d  = ld_ptr_q + 13'd1;
                    if (ld_last) begin
                        state_d   = IDLE;
                        ld_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Held low through the done pulse so the CPU starts only after the final byte lands.
        cpu_resetn_d = (state_d != LOAD) && !ld_done_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            ram_ce_q     <= 1'b0;
            ram_wre_q    <= 4'b0000;
            ram_ad_q     <= 11'd0;
            ram_din_q    <= 32'd0;
            mem_ready_q  <= 1'b0;
            mem_rdata_q  <= 32'd0;
            ld_done_q    <= 1'b0;
            cpu_resetn_q <= 1'b0;
            ld_ptr_q     <= 13'd0;
        end else begin
            state_q      <= state_d;
            ram_ce_q     <= ram_ce_d;
            ram_wre_q    <= ram_wre_d;
            ram_ad_q     <= ram_ad_d;
            ram_din_q    <= ram_din_d;
            mem_ready_q  <= mem_ready_d;
            mem_rdata_q  <= mem_rdata_d;
            ld_done_q    <= ld_done_d;
            cpu_resetn_q <= cpu_resetn_d;
            ld_ptr_q     <= ld_ptr_d;
        end
    end

    assign mem_ready  = mem_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign ram_ce     = ram_ce_q;
    assign ram_wre    = ram_wre_q;
    assign ram_ad     = ram_ad_q;
    assign ram_din    = ram_din_q;
    assign ld_ready   = (state_q == LOAD);
    assign ld_done    = ld_done_q;
    assign cpu_resetn = cpu_resetn_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Self-checking bench for bootram_ctrl: byte-lane RAM environment, byte-addressed
// reference memory, directed and randomized CPU/loader traffic, resets mid-operation.
module tb_bootram_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ram_ce;
    logic [3:0]  ram_wre;
    logic [10:0] ram_ad;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = 32'd0;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_done;
    logic        cpu_resetn;
    logic [2:0]  state_dbg;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model: flat byte-addressed image of the 8 KB window.
    logic [7:0]  model_mem [8192];
    int          model_ptr;
    logic [31:0] exp_q [$];
    logic [31:0] last_rdata;
    logic [7:0]  ld_q [$];

    // Environment: four byte-lane synchronous RAMs with a bench-only preload port.
    logic [31:0] ram_arr [2048];
    logic        pre_we = 1'b0;
    logic [10:0] pre_addr = 11'd0;
    logic [31:0] pre_data = 32'd0;
    int          wr_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            ram_arr[pre_addr] <= pre_data;
        end else if (ram_ce) begin
            for (int n = 0; n < 4; n++)
                if (ram_wre[n]) ram_arr[ram_ad][8*n +: 8] <= ram_din[8*n +: 8];
            if (ram_wre != 4'b0000) wr_count <= wr_count + 1;
            ram_dout <= ram_arr[ram_ad];
        end
    end

    bootram_ctrl #(.BASE_ADDR(32'h0000_0000), .ADDR_BITS(13)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din),
        .ram_dout(ram_dout),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .cpu_resetn(cpu_resetn),
        .state_dbg(state_dbg)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_word(input int widx);
        return {model_mem[4*widx+3], model_mem[4*widx+2], model_mem[4*widx+1], model_mem[4*widx]};
    endfunction

    task automatic check_all_zero(input string tag);
        check1({tag, "_mem_ready"}, mem_ready, 1'b0);
        check32({tag, "_mem_rdata"}, mem_rdata, 32'd0);
        check1({tag, "_ram_ce"}, ram_ce, 1'b0);
        check32({tag, "_ram_wre"}, 32'(ram_wre), 32'd0);
        check32({tag, "_ram_ad"}, 32'(ram_ad), 32'd0);
        check32({tag, "_ram_din"}, ram_din, 32'd0);
        check1({tag, "_ld_ready"}, ld_ready, 1'b0);
        check1({tag, "_ld_done"}, ld_done, 1'b0);
        check1({tag, "_cpu_resetn"}, cpu_resetn, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] addr);
        int widx;
        logic [31:0] exp;
        widx = int'(addr[12:2]);
        exp_q.push_back(model_word(widx));
        mem_valid = 1'b1; mem_addr = addr; mem_wstrb = 4'b0000; mem_wdata = $urandom;
        tick();
        check1("rd_ce", ram_ce, 1'b1);
        check32("rd_ad", 32'(ram_ad), 32'(widx));
        check32("rd_wre", 32'(ram_wre), 32'd0);
        check1("rd_ready_c1", mem_ready, 1'b0);
        check1("rd_cpu_resetn", cpu_resetn, 1'b1);
        check1("rd_ld_ready", ld_ready, 1'b0);
        tick();
        check1("rd_ready_c2", mem_ready, 1'b0);
        check1("rd_ce_c2", ram_ce, 1'b0);
        tick();
        check1("rd_ready_c3", mem_ready, 1'b1);
        exp = exp_q.pop_front();
        check32("rd_data", mem_rdata, exp);
        last_rdata = exp;
        tick();
        check1("rd_no_dup_ready", mem_ready, 1'b0);
        check1("rd_no_dup_ce", ram_ce, 1'b0);
        check32("rd_hold", mem_rdata, last_rdata);
        mem_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int widx;
        widx = int'(addr[12:2]);
        mem_valid = 1'b1; mem_addr = addr; mem_wstrb = strb; mem_wdata = data;
        tick();
        check1("wr_ce", ram_ce, 1'b1);
        check32("wr_wre", 32'(ram_wre), 32'(strb));
        check32("wr_ad", 32'(ram_ad), 32'(widx));
        check32("wr_din", ram_din, data);
        check1("wr_ready_c1", mem_ready, 1'b0);
        tick();
        check1("wr_ready_c2", mem_ready, 1'b1);
        check1("wr_ce_c2", ram_ce, 1'b0);
        check32("wr_wre_c2", 32'(ram_wre), 32'd0);
        check32("wr_rdata_hold", mem_rdata, last_rdata);
        for (int i = 0; i < 4; i++)
            if (strb[i]) model_mem[4*widx+i] = data[8*i +: 8];
        tick();
        check1("wr_no_dup_ready", mem_ready, 1'b0);
        check1("wr_no_dup_ce", ram_ce, 1'b0);
        mem_valid = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] addr);
        mem_valid = 1'b1; mem_addr = addr; mem_wstrb = 4'($urandom_range(0, 15)); mem_wdata = $urandom;
        for (int i = 0; i < 10; i++) begin
            tick();
            check1("miss_ce", ram_ce, 1'b0);
            check1("miss_ready", mem_ready, 1'b0);
        end
        mem_valid = 1'b0;
    endtask

    // Streams ld_q through the loader; optionally holds a CPU read request the whole time.
    task automatic do_load(input bit with_mem, input int gap_pct);
        int n;
        logic [7:0] b;
        logic [3:0] exp_wre;
        n = ld_q.size();
        ld_start = 1'b1;
        if (with_mem) begin
            mem_valid = 1'b1; mem_addr = 32'h0000_0000; mem_wstrb = 4'b0000;
        end
        tick();
        check1("ld_enter_ready", ld_ready, 1'b1);
        check1("ld_enter_cpu_resetn", cpu_resetn, 1'b0);
        check1("ld_enter_ce", ram_ce, 1'b0);
        check1("ld_enter_mem_ready", mem_ready, 1'b0);
        ld_start = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                ld_valid = 1'b0;
                ld_start = 1'($urandom_range(0, 1));
                tick();
                check1("ld_gap_ready", ld_ready, 1'b1);
                check1("ld_gap_ce", ram_ce, 1'b0);
                check32("ld_gap_wre", 32'(ram_wre), 32'd0);
                check1("ld_gap_mem_ready", mem_ready, 1'b0);
            end
            b = ld_q[i];
            ld_valid = 1'b1; ld_data = b; ld_last = (i == n - 1);
            ld_start = 1'($urandom_range(0, 1));
            tick();
            exp_wre = 4'b0000;
            exp_wre[model_ptr % 4] = 1'b1;
            check1("ld_ce", ram_ce, 1'b1);
            check32("ld_ad", 32'(ram_ad), 32'(model_ptr / 4));
            check32("ld_wre", 32'(exp_wre), 32'(ram_wre));
            check32("ld_din", ram_din, {4{b}});
            check1("ld_cpu_resetn", cpu_resetn, 1'b0);
            check1("ld_mem_ready", mem_ready, 1'b0);
            check1("ld_ready_after", ld_ready, (i != n - 1));
            check1("ld_done_pulse", ld_done, (i == n - 1));
            model_mem[model_ptr] = b;
            model_ptr = (model_ptr + 1) % 8192;
        end
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0; mem_valid = 1'b0;
        tick();
        check1("ld_done_drop", ld_done, 1'b0);
        check1("ld_cpu_release", cpu_resetn, 1'b1);
        check1("ld_post_ce", ram_ce, 1'b0);
        check32("ld_post_wre", 32'(ram_wre), 32'd0);
        check1("ld_post_ready", ld_ready, 1'b0);
        check1("ld_post_mem_ready", mem_ready, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        int op;
        int wc;

        resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'd0; ld_last = 1'b0;
        last_rdata = 32'd0; model_ptr = 0;
        for (int i = 0; i < 8192; i++) model_mem[i] = 8'h00;
        model_mem[0] = 8'h13; model_mem[1] = 8'h05;

        // Clear the RAM and preload word 0 while the controller is held in reset.
        #1;
        pre_we = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            pre_addr = 11'(i); pre_data = 32'd0;
            tick();
        end
        pre_addr = 11'd0; pre_data = 32'h0000_0513;
        tick();
        pre_we = 1'b0;
        check_all_zero("reset");

        resetn = 1'b1;
        #1;
        check1("cpu_resetn_before_edge", cpu_resetn, 1'b0);
        tick();
        check1("cpu_resetn_first_edge", cpu_resetn, 1'b1);
        check1("idle_ld_ready", ld_ready, 1'b0);

        // Boot word read-hit, then byte write and readback.
        do_read(32'h0000_0000);
        check32("boot_word0", mem_rdata, 32'h0000_0513);
        do_write(32'h0000_0008, 32'hAABB_CCDD, 4'b0010);
        do_read(32'h0000_0008);
        check32("byte_lane1_readback", mem_rdata, 32'h0000_CC00);

        do_miss(32'h0000_2000);

        // Five-byte load session.
        ld_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_load(1'b0, 0);
        do_read(32'h0000_0000);
        check32("load_word0", mem_rdata, 32'h4433_2211);
        do_read(32'h0000_0004);
        check32("load_word1", mem_rdata, 32'h0000_0055);

        // ld_start together with a CPU request: the loader wins.
        ld_q.delete();
        for (int i = 0; i < 6; i++) ld_q.push_back(8'($urandom));
        do_load(1'b1, 30);

        // Randomized CPU traffic against the byte model.
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 9);
            a = {19'd0, 13'($urandom)};
            if (op == 0) begin
                a = $urandom;
                if (a[31:13] == 19'd0) a[13] = 1'b1;
                do_miss(a);
            end else if (op < 5) begin
                do_write(a, $urandom, 4'($urandom_range(1, 15)));
            end else begin
                do_read(a);
            end
        end

        // Full-window load that wraps the byte pointer back to zero.
        ld_q.delete();
        for (int i = 0; i < 8194; i++) ld_q.push_back(8'($urandom));
        do_load(1'b0, 0);
        do_read(32'h0000_0000);
        do_read(32'h0000_1FFC);
        for (int k = 0; k < 8; k++) do_read({19'd0, 13'($urandom)});

        // Reset during a read.
        mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wstrb = 4'b0000;
        tick();
        resetn = 1'b0;
        #1;
        check_all_zero("rst_mid_read");
        last_rdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("rst_rd_no_ready", mem_ready, 1'b0);
        end
        mem_valid = 1'b0;
        resetn = 1'b1;
        tick();
        check1("rst_rd_release", cpu_resetn, 1'b1);

        // Reset during a write: the pending RAM write must not happen.
        wc = wr_count;
        mem_valid = 1'b1; mem_addr = 32'h0000_0020; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b1111;
        tick();
        resetn = 1'b0;
        #1;
        check_all_zero("rst_mid_write");
        for (int i = 0; i < 3; i++) tick();
        check32("rst_wr_no_write", 32'(wr_count), 32'(wc));
        mem_valid = 1'b0;
        resetn = 1'b1;
        tick();
        do_read(32'h0000_0020);

        // Reset after three loader bytes: only the first two reach the RAM.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_q = '{8'hA1, 8'hB2, 8'hC3};
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = ld_q[i]; ld_last = 1'b0;
            tick();
        end
        resetn = 1'b0;
        #1;
        check_all_zero("rst_mid_load");
        wc = wr_count;
        model_mem[0] = 8'hA1; model_mem[1] = 8'hB2;
        for (int i = 0; i < 3; i++) tick();
        check32("rst_ld_no_write", 32'(wr_count), 32'(wc));
        ld_valid = 1'b0;
        resetn = 1'b1;
        tick();
        check1("rst_ld_release", cpu_resetn, 1'b1);
        ld_q = '{8'h5A, 8'hC7};
        do_load(1'b0, 0);
        do_read(32'h0000_0000);

        check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
